// File: rtl/call_ret_ctrl.sv
// Call/return sequencer between the CPU control unit and the return-address stack.
// Optional depth counter: define CALLRET_DEPTH_CNT_EN.
module call_ret_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [ADDR_W-1:0] ret_addr_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] target_out,
  output logic              target_valid,
  output logic              fault,
  output logic [1:0]        fault_code,
  input  logic              fault_clr,
  output logic [CNT_W-1:0]  depth,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [ADDR_W-1:0] stk_din,
  input  logic [ADDR_W-1:0] stk_dout,
  input  logic              stk_empty,
  input  logic              stk_full
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    POP   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] tgt_q;
  logic [1:0]        code_q, code_d;
  logic              ret_q;
  logic              ovf, unf;

  if (2 ** CNT_W <= DEPTH) begin : g_cnt_w_check
    $error("CNT_W too narrow to count DEPTH entries");
  end

`ifdef CALLRET_DEPTH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (state_q == PUSH) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == POP) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign depth = cnt_q;
  assign ovf   = stk_full || (cnt_q == CNT_W'(DEPTH));
  assign unf   = stk_empty || (cnt_q == '0);
`else
  assign depth = '0;
  assign ovf   = stk_full;
  assign unf   = stk_empty;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      tgt_q   <= '0;
      code_q  <= '0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
      if (state_q == WAIT) tgt_q <= stk_dout;
      // remembers which operation DONE is completing
      if (state_q == POP) ret_q <= 1'b1;
      else if (state_q == PUSH) ret_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (call_req && ret_req) begin
          state_d = FAULT;
          code_d  = 2'b11;
        end else if (call_req) begin
          if (ovf) begin
            state_d = FAULT;
            code_d  = 2'b01;
          end else begin
            state_d = PUSH;
            addr_d  = ret_addr_in;
          end
        end else if (ret_req) begin
          if (unf) begin
            state_d = FAULT;
            code_d  = 2'b10;
          end else begin
            state_d = POP;
          end
        end
      end
      PUSH: state_d = DONE;
      POP:  state_d = WAIT;
      WAIT: state_d = DONE;
      DONE: state_d = IDLE;
      FAULT: begin
        if (fault_clr) begin
          state_d = IDLE;
          code_d  = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stk_push     = (state_q == PUSH);
  assign stk_pop      = (state_q == POP);
  assign stk_din      = addr_q;
  assign busy         = (state_q == PUSH) || (state_q == POP) ||
                        (state_q == WAIT) || (state_q == DONE);
  assign done         = (state_q == DONE);
  assign target_valid = (state_q == DONE) && ret_q;
  assign fault        = (state_q == FAULT);
  assign fault_code   = code_q;
  assign target_out   = tgt_q;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Bench for call_ret_ctrl: attached stack model, transaction-level reference
// model compared every cycle, plus directed literal checks.
module tb_call_ret_ctrl;
  localparam int AW = 8;
  localparam int DP = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          call_req, ret_req, fault_clr;
  logic [AW-1:0] ret_addr_in;
  logic          busy, done, target_valid, fault;
  logic [AW-1:0] target_out, stk_din, stk_dout;
  logic [1:0]    fault_code;
  logic [CW-1:0] depth;
  logic          stk_push, stk_pop, stk_empty, stk_full;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  call_ret_ctrl #(.ADDR_W(AW), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .call_req(call_req), .ret_req(ret_req), .ret_addr_in(ret_addr_in),
    .busy(busy), .done(done), .target_out(target_out),
    .target_valid(target_valid), .fault(fault), .fault_code(fault_code),
    .fault_clr(fault_clr), .depth(depth),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_empty(stk_empty), .stk_full(stk_full)
  );

  // attached return-address stack, one-cycle read latency
  logic [AW-1:0] mem [DP];
  int sp;
  always @(posedge clk) begin
    if (!rstn) begin
      sp <= 0;
    end else if (stk_push && sp < DP) begin
      mem[sp] <= stk_din;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= mem[sp-1];
      sp       <= sp - 1;
    end
  end
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == DP);

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", n, $time, a, e);
    end
  endtask

  // reference model: operation in progress plus cycle index within it
  typedef enum {M_IDLE, M_CALL, M_RET, M_FLT} mop_t;
  mop_t          m_op;
  int            m_k;
  logic [AW-1:0] m_addr, m_tgt, m_pend;
  logic [1:0]    m_code;
  logic [AW-1:0] mq[$];
  bit            live = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_op = M_IDLE; m_k = 0; m_addr = '0; m_tgt = '0;
      m_code = 2'b00; mq.delete(); live = 1;
    end else begin
      case (m_op)
        M_IDLE: begin
          if (call_req && ret_req) begin
            m_op = M_FLT; m_code = 2'b11;
          end else if (call_req) begin
            if (mq.size() >= DP) begin
              m_op = M_FLT; m_code = 2'b01;
            end else begin
              m_addr = ret_addr_in; m_op = M_CALL; m_k = 1;
            end
          end else if (ret_req) begin
            if (mq.size() == 0) begin
              m_op = M_FLT; m_code = 2'b10;
            end else begin
              m_op = M_RET; m_k = 1;
            end
          end
        end
        M_CALL: begin
          if (m_k == 1) mq.push_back(m_addr);
          m_k++;
          if (m_k == 3) m_op = M_IDLE;
        end
        M_RET: begin
          if (m_k == 1) m_pend = mq.pop_back();
          if (m_k == 2) m_tgt = m_pend;
          m_k++;
          if (m_k == 4) m_op = M_IDLE;
        end
        M_FLT: begin
          if (fault_clr) begin
            m_op = M_IDLE; m_code = 2'b00;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (live) begin
      logic [31:0] e_depth;
`ifdef CALLRET_DEPTH_CNT_EN
      e_depth = 32'(mq.size());
`else
      e_depth = 0;
`endif
      chk("m_busy", busy, m_op == M_CALL || m_op == M_RET);
      chk("m_done", done, (m_op == M_CALL && m_k == 2) || (m_op == M_RET && m_k == 3));
      chk("m_tvalid", target_valid, m_op == M_RET && m_k == 3);
      chk("m_push", stk_push, m_op == M_CALL && m_k == 1);
      chk("m_pop", stk_pop, m_op == M_RET && m_k == 1);
      chk("m_din", stk_din, m_addr);
      chk("m_target", target_out, m_tgt);
      chk("m_fault", fault, m_op == M_FLT);
      chk("m_code", fault_code, m_code);
      chk("m_depth", depth, e_depth);
    end
  end

  task automatic req(input logic c, input logic r, input logic [AW-1:0] a);
    @(negedge clk); #1;
    call_req = c; ret_req = r; ret_addr_in = a;
    @(negedge clk); #1;
    call_req = 1'b0; ret_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8; i++) begin
      if (!busy) return;
      @(negedge clk); #1;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1; rstn = 1'b0;
    @(negedge clk); #1; rstn = 1'b1;
  endtask

  task automatic clear_fault();
    @(negedge clk); #1; fault_clr = 1'b1;
    @(negedge clk); #1;
    chk("clr_fault", fault, 1'b0);
    chk("clr_code", fault_code, 2'b00);
    fault_clr = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; call_req = 1'b0; ret_req = 1'b0;
    fault_clr = 1'b0; ret_addr_in = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_target", target_out, 8'h00);
    chk("rst_code", fault_code, 2'b00);
    chk("rst_depth", depth, 4'd0);
    rstn = 1'b1;

    req(1'b1, 1'b0, 8'h2A);
    chk("c1_push", stk_push, 1'b1);
    chk("c1_din", stk_din, 8'h2A);
    @(negedge clk); #1;
    chk("c2_done", done, 1'b1);
    chk("c2_tvalid", target_valid, 1'b0);
`ifdef CALLRET_DEPTH_CNT_EN
    chk("c2_depth", depth, 4'd1);
`endif
    wait_idle();

    req(1'b1, 1'b0, 8'h10); wait_idle();
    req(1'b1, 1'b0, 8'h20); wait_idle();
    req(1'b0, 1'b1, 8'h00);
    chk("r1_pop", stk_pop, 1'b1);
    @(negedge clk); #1;
    chk("r1_pop_once", stk_pop, 1'b0);
    @(negedge clk); #1;
    chk("r1_tvalid", target_valid, 1'b1);
    chk("r1_target", target_out, 8'h20);
    wait_idle();
    req(1'b0, 1'b1, 8'h00);
    @(negedge clk); @(negedge clk); #1;
    chk("r2_tvalid", target_valid, 1'b1);
    chk("r2_target", target_out, 8'h10);
    wait_idle();
    req(1'b0, 1'b1, 8'h00); wait_idle();

    do_reset();
    req(1'b0, 1'b1, 8'h00);
    chk("unf_fault", fault, 1'b1);
    chk("unf_code", fault_code, 2'b10);
    chk("unf_pop", stk_pop, 1'b0);
    clear_fault();

    do_reset();
    for (int i = 0; i < DP; i++) begin
      req(1'b1, 1'b0, AW'(i * 3 + 1));
      wait_idle();
    end
    req(1'b1, 1'b0, 8'hEE);
    chk("ovf_code", fault_code, 2'b01);
    chk("ovf_push", stk_push, 1'b0);
    @(negedge clk); #1;
    chk("ovf_push2", stk_push, 1'b0);
    clear_fault();

    req(1'b1, 1'b1, 8'h77);
    chk("cfl_code", fault_code, 2'b11);
    chk("cfl_push", stk_push, 1'b0);
    chk("cfl_pop", stk_pop, 1'b0);
    clear_fault();

    do_reset();
    req(1'b1, 1'b0, 8'h55);
    call_req = 1'b1; ret_addr_in = 8'h99;
    @(negedge clk); #1;
    call_req = 1'b0;
    chk("busy_din", stk_din, 8'h55);
    wait_idle();
`ifdef CALLRET_DEPTH_CNT_EN
    chk("busy_depth", depth, 4'd1);
`endif
    req(1'b1, 1'b0, 8'h66); wait_idle();
    req(1'b0, 1'b1, 8'h00); wait_idle();
    chk("pre_rst_target", target_out, 8'h66);

    req(1'b0, 1'b1, 8'h00);
    @(negedge clk); #1;
    rstn = 1'b0;
    @(negedge clk); #1;
    chk("rw_busy", busy, 1'b0);
    chk("rw_target", target_out, 8'h00);
    chk("rw_done", done, 1'b0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
